sync_filter_block: RTL and testbench
====================================

# sync_filter_block

Parametrised multi-bit synchronizer with per-bit glitch filter and edge-detect outputs. Brings asynchronous status/control signals (PHY link, MDIO-side flags, external buttons, cross-clock levels) into the `clk` domain through a configurable-depth flip-flop chain. Requires each synchronized bit to be stable for a programmable number of cycles before updating its output, and emits single-cycle rise/fall pulses. Intended as a drop-in replacement for the plain two-stage synchronizer in the TEMAC and filter control paths.

## Interface
- `WIDTH`, 1, number of independent bits (1..32)
- `STAGES`, 2, synchronizer flip-flop depth per bit (2..4)
- `FILTER_CNT`, 1, consecutive stable cycles required before `data_out` follows (1..255); 1 = no filtering
- `INIT`, 1'b0, reset value replicated into every synchronizer stage and `data_out` bit
- `clk`  input  1  system clock; all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset; deassertion assumed synchronous to `clk` externally
- `data_in`  input  WIDTH  asynchronous inputs, no timing relationship to `clk`
- `data_out`  output  WIDTH  synchronized, filtered level
- `rise`  output  WIDTH  one-cycle pulse, bit i went 0→1 on `data_out`
- `fall`  output  WIDTH  one-cycle pulse, bit i went 1→0 on `data_out`
- `changed`  output  1  OR-reduction of `rise | fall`, same cycle

## Operation
- Per bit i, fully independent; no cross-bit coherency (not a bus synchronizer; multi-bit values may update in different cycles).
- Sync chain: `STAGES` registers, `s[0] <= data_in[i]`, `s[k] <= s[k-1]`; `sync[i] = s[STAGES-1]`. First stage is the only register touching `data_in`; no logic between chain stages.
- Filter counter `cnt[i]`, width ceil(log2(FILTER_CNT)) (min 1 bit):
  - `sync[i] == data_out[i]`: `cnt <= 0`.
  - `sync[i] != data_out[i]` and `cnt < FILTER_CNT-1`: `cnt <= cnt+1`.
  - `sync[i] != data_out[i]` and `cnt == FILTER_CNT-1`: `data_out[i] <= sync[i]`, `cnt <= 0`, pulse `rise[i]` (if new value 1) or `fall[i]` (if 0).
- `rise`/`fall`/`changed` are registered, high exactly one cycle, coincident with the `data_out` transition cycle. `rise[i]` and `fall[i]` never high together.
- Glitch shorter than `FILTER_CNT` consecutive cycles at `sync[i]` is rejected: counter clears, `data_out` and pulses unchanged.
- Counter never exceeds `FILTER_CNT-1`; no wrap.
- Reset (`rst_n` low, any time, including mid-count): all sync stages and `data_out` = `INIT`, `cnt` = 0, `rise`/`fall`/`changed` = 0, immediately (asynchronous). No pulse generated on reset entry or exit; first pulse only after a genuine filtered change relative to `INIT`.
- Parameter out of range: elaboration-time error (generate-time check), not silent clamping.

## Timing
- Latency, `data_in` change captured at rising edge E0 → `sync` valid after edge E0+STAGES-1 → `data_out`/pulse updated at edge E0+STAGES-1+FILTER_CNT. Defaults (2,1): `data_out` changes 2 edges after capture.
- Input must hold ≥ FILTER_CNT cycles at the chain output to propagate; metastability may shift capture by ±1 cycle; verification tolerates ±1.
- All outputs registered; no combinational path from `data_in` to any output.
- Max toggle rate passed: one transition per FILTER_CNT cycles per bit.

## Test plan
- Reset: `INIT=1`, `WIDTH=4`, hold `rst_n=0`, `data_in=4'h0` → `data_out=4'hF`, `rise=fall=0`, `changed=0`; release reset, `data_in=4'hF` held → no pulses ever.
- Basic latency, defaults: `data_in` 0→1 captured at edge 10 → `data_out=1` and `rise=1` at edge 12, `rise=0` at edge 13; 1→0 gives `fall` with same latency.
- Filter, `FILTER_CNT=4`, `STAGES=3`: 3-cycle high pulse on `data_in` → `data_out` stays 0, no pulses; 4-cycle pulse → `data_out` high for 4 cycles, exactly one `rise` then one `fall`.
- Independence, `WIDTH=8`: bits 0 and 7 toggle same cycle, bit 3 glitches 1 cycle with `FILTER_CNT=2` → `rise=8'h81`, `changed=1` one cycle, bit 3 unaffected.
- Reset mid-operation: `FILTER_CNT=8`, drive change, assert `rst_n=0` when `cnt=5` → outputs return to `INIT` immediately; after release with same input, full 8-cycle wait restarts before update.
- Random: random `data_in` per bit with random hold times 1..20 vs reference model → `data_out`, `rise`, `fall` match within ±1 cycle; never `rise&fall`.

Source files
------------

// File: rtl/sync_filter_block_if.sv
// Port bundle for sync_filter_block.
//   data_in  : asynchronous inputs, driven by the source side
//   data_out : synchronized, filtered levels
//   rise     : one-cycle pulse per bit on a filtered 0->1 change
//   fall     : one-cycle pulse per bit on a filtered 1->0 change
//   changed  : OR of rise|fall, same cycle
// master = source/consumer side, slave = the synchronizer block.
interface sync_filter_block_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output data_in,
        input  data_out,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  data_in,
        output data_out,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/sync_filter_block.sv
// Multi-bit synchronizer with per-bit glitch filter and edge pulses.
// Each bit passes through a STAGES-deep flop chain, then must hold a value
// different from data_out for FILTER_CNT consecutive cycles before data_out
// follows. rise/fall/changed pulse for one cycle with the data_out update.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport (data_in in; data_out, rise, fall, changed out)
module sync_filter_block #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned FILTER_CNT = 1,
    parameter logic        INIT       = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_filter_block_if.slave  bus
);

    localparam int unsigned      CNT_W    = (FILTER_CNT > 2) ? $clog2(FILTER_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FILTER_CNT - 1);
    localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT}};

    // Elaboration-time parameter range checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
        $error("sync_filter_block: WIDTH must be in 1..32");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_chk_stages
        $error("sync_filter_block: STAGES must be in 2..4");
    end
    if (FILTER_CNT < 1 || FILTER_CNT > 255) begin : g_chk_filter
        $error("sync_filter_block: FILTER_CNT must be in 1..255");
    end

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_bits;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             changed_q;
    logic             changed_d;

    // Plain flop chain; stage 0 is the only flop that sees data_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                sync_q[k] <= INIT_VEC;
            end
        end else begin
            sync_q[0] <= bus.data_in;
            for (int k = 1; k < int'(STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_bits = sync_q[STAGES-1];

    // Per-bit stability counter: clears whenever the synchronized bit agrees
    // with data_out, so any shorter excursion is discarded.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync_bits[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]  = '0;
                out_d[i]  = sync_bits[i];
                rise_d[i] = sync_bits[i];
                fall_d[i] = ~sync_bits[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
            out_q     <= INIT_VEC;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign bus.data_out = out_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.changed  = changed_q;

endmodule

// File: tb/tb_sync_filter_block.sv
// Self-checking bench for sync_filter_block: several parameterisations
// sharing one clock, directed scenarios plus a scoreboarded random run.
module tb_sync_filter_block;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_e_n = 1'b0;
    int   cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a: reset/INIT=1, b: defaults, c: filter/random, d: independence, e: mid-reset
    sync_filter_block_if #(.WIDTH(4)) if_a ();
    sync_filter_block_if #(.WIDTH(1)) if_b ();
    sync_filter_block_if #(.WIDTH(8)) if_c ();
    sync_filter_block_if #(.WIDTH(8)) if_d ();
    sync_filter_block_if #(.WIDTH(1)) if_e ();

    sync_filter_block #(.WIDTH(4), .STAGES(2), .FILTER_CNT(1), .INIT(1'b1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    sync_filter_block #(.WIDTH(1), .STAGES(2), .FILTER_CNT(1), .INIT(1'b0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    sync_filter_block #(.WIDTH(8), .STAGES(3), .FILTER_CNT(4), .INIT(1'b0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    sync_filter_block #(.WIDTH(8), .STAGES(2), .FILTER_CNT(2), .INIT(1'b0))
        u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));
    sync_filter_block #(.WIDTH(1), .STAGES(2), .FILTER_CNT(8), .INIT(1'b0))
        u_e (.clk(clk), .rst_n(rst_e_n), .bus(if_e));

    typedef struct {
        int   ev_edge;
        int   ev_bit;
        logic ev_val;
    } ev_t;

    ev_t evq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if_a.data_in = 4'h0;
        if_b.data_in = 1'b0;
        if_c.data_in = 8'h00;
        if_d.data_in = 8'h00;
        if_e.data_in = 1'b0;
        tick();
        tick();
        vectors++;
        if ({if_a.data_out, if_a.rise, if_a.fall, if_a.changed} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: out=%h rise=%h fall=%h chg=%b, want out=f rise=0 fall=0 chg=0",
                     if_a.data_out, if_a.rise, if_a.fall, if_a.changed);
        end
        if_a.data_in = 4'hF;
        tick();
        rst_n = 1'b1;
        rst_e_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if ({if_a.data_out, if_a.rise, if_a.fall, if_a.changed} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_release cyc %0d: out=%h rise=%h fall=%h chg=%b, want f/0/0/0",
                         k, if_a.data_out, if_a.rise, if_a.fall, if_a.changed);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] expv;
        for (int dir = 0; dir < 2; dir++) begin
            tick();
            if_b.data_in = (dir == 0) ? 1'b1 : 1'b0;
            // k is the edge offset from the capturing edge
            for (int k = 0; k <= 3; k++) begin
                tick();
                if (dir == 0) expv = {(k >= 2), (k == 2), 1'b0, (k == 2)};
                else          expv = {(k < 2), 1'b0, (k == 2), (k == 2)};
                vectors++;
                if ({if_b.data_out, if_b.rise, if_b.fall, if_b.changed} !== expv) begin
                    miscompares++;
                    $display("FAIL latency dir%0d E0+%0d: out/rise/fall/chg=%b, want %b",
                             dir, k, {if_b.data_out, if_b.rise, if_b.fall, if_b.changed}, expv);
                end
            end
            for (int k = 0; k < 3; k++) tick();
        end
    endtask

    task automatic test_filter();
        int rises, falls, chgs, hi, rise_at, fall_at, other;
        for (int n = 3; n <= 4; n++) begin
            rises = 0; falls = 0; chgs = 0; hi = 0; rise_at = -1; fall_at = -1; other = 0;
            tick();
            if_c.data_in[0] = 1'b1;
            for (int k = 0; k < 30; k++) begin
                if (k == n) if_c.data_in[0] = 1'b0;
                tick();
                if (if_c.rise[0]) begin rises++; rise_at = k; end
                if (if_c.fall[0]) begin falls++; fall_at = k; end
                if (if_c.changed) chgs++;
                if (if_c.data_out[0]) hi++;
                if ((if_c.rise[7:1] | if_c.fall[7:1] | if_c.data_out[7:1]) != 7'd0) other++;
            end
            vectors++;
            if (n == 3) begin
                if ({rises, falls, chgs, hi, other} !== {32'd0, 32'd0, 32'd0, 32'd0, 32'd0}) begin
                    miscompares++;
                    $display("FAIL filter_glitch3: rises=%0d falls=%0d chg=%0d hi=%0d other=%0d, want all 0",
                             rises, falls, chgs, hi, other);
                end
            end else begin
                if ({rises, falls, chgs, hi, rise_at, fall_at, other} !==
                    {32'd1, 32'd1, 32'd2, 32'd4, 32'd6, 32'd10, 32'd0}) begin
                    miscompares++;
                    $display("FAIL filter_pass4: rises=%0d falls=%0d chg=%0d hi=%0d rise@%0d fall@%0d other=%0d, want 1 1 2 4 6 10 0",
                             rises, falls, chgs, hi, rise_at, fall_at, other);
                end
            end
        end
    endtask

    task automatic test_independence();
        int chgs, chg_at, falls, b3;
        logic [7:0] rise_seen;
        chgs = 0; chg_at = -1; falls = 0; b3 = 0; rise_seen = 8'h00;
        tick();
        if_d.data_in = 8'h89;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) if_d.data_in = 8'h81;
            tick();
            if (if_d.changed) begin chgs++; chg_at = k; rise_seen = if_d.rise; end
            if (if_d.fall != 8'h00) falls++;
            if (if_d.data_out[3]) b3++;
        end
        vectors++;
        if ({chgs, chg_at, falls, b3} !== {32'd1, 32'd3, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL indep_timing: chg=%0d chg@%0d falls=%0d bit3_hi=%0d, want 1 3 0 0",
                     chgs, chg_at, falls, b3);
        end
        vectors++;
        if ({rise_seen, if_d.data_out} !== {8'h81, 8'h81}) begin
            miscompares++;
            $display("FAIL indep_value: rise=%h out=%h, want 81 81", rise_seen, if_d.data_out);
        end
        if_d.data_in = 8'h00;
    endtask

    task automatic test_reset_mid();
        logic [3:0] expv;
        if_e.data_in = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        vectors++;
        if (if_e.data_out !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_setup: out=%b, want 1", if_e.data_out);
        end
        tick();
        if_e.data_in = 1'b0;
        // edges E0..E0+6: counter reaches 5 after E0+6
        for (int k = 0; k <= 6; k++) tick();
        vectors++;
        if (if_e.data_out !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_counting: out=%b, want 1", if_e.data_out);
        end
        rst_e_n = 1'b0;
        #1;
        vectors++;
        if ({if_e.data_out, if_e.rise, if_e.fall, if_e.changed} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_async: out/rise/fall/chg=%b, want 0000",
                     {if_e.data_out, if_e.rise, if_e.fall, if_e.changed});
        end
        if_e.data_in = 1'b1;
        tick();
        tick();
        rst_e_n = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            expv = {(k >= 9), (k == 9), 1'b0, (k == 9)};
            vectors++;
            if ({if_e.data_out, if_e.rise, if_e.fall, if_e.changed} !== expv) begin
                miscompares++;
                $display("FAIL midrst_restart R1+%0d: out/rise/fall/chg=%b, want %b",
                         k, {if_e.data_out, if_e.rise, if_e.fall, if_e.changed}, expv);
            end
        end
    endtask

    // Scoreboard: when a bit starts a new input run, the model decides whether
    // that run is long enough to move the filtered output and queues the edge.
    task automatic test_random();
        localparam int N   = 1500;
        localparam int LAT = 6;
        localparam int F   = 4;
        logic [7:0] cur_in, mod_out, exp_out, exp_rise, exp_fall;
        int         hold [8];
        int         e, h;
        ev_t        ev;
        cur_in = 8'h00; mod_out = 8'h00; exp_out = 8'h00;
        for (int b = 0; b < 8; b++) hold[b] = 0;
        if_c.data_in = 8'h00;
        for (int k = 0; k < 20; k++) tick();
        for (int t = 0; t < N; t++) begin
            tick();
            e = cyc;
            exp_rise = 8'h00;
            exp_fall = 8'h00;
            while (evq.size() > 0 && evq[0].ev_edge == e) begin
                ev = evq.pop_front();
                if (ev.ev_val) exp_rise[ev.ev_bit] = 1'b1;
                else           exp_fall[ev.ev_bit] = 1'b1;
                exp_out[ev.ev_bit] = ev.ev_val;
            end
            vectors++;
            if ({if_c.data_out, if_c.rise, if_c.fall, if_c.changed} !==
                {exp_out, exp_rise, exp_fall, |(exp_rise | exp_fall)}) begin
                miscompares++;
                $display("FAIL random t=%0d: out=%h rise=%h fall=%h chg=%b, want out=%h rise=%h fall=%h chg=%b",
                         t, if_c.data_out, if_c.rise, if_c.fall, if_c.changed,
                         exp_out, exp_rise, exp_fall, |(exp_rise | exp_fall));
            end
            vectors++;
            if ((if_c.rise & if_c.fall) !== 8'h00) begin
                miscompares++;
                $display("FAIL random_rise_and_fall t=%0d: rise&fall=%h, want 00", t, if_c.rise & if_c.fall);
            end
            for (int b = 0; b < 8; b++) begin
                if (hold[b] == 0 && t < N - 40) begin
                    h = int'($urandom_range(1, 20));
                    cur_in[b] = ~cur_in[b];
                    hold[b] = h;
                    if (cur_in[b] != mod_out[b] && h >= F) begin
                        mod_out[b] = cur_in[b];
                        evq.push_back('{e + 1 + LAT, b, cur_in[b]});
                    end
                end
                if (hold[b] > 0) hold[b]--;
            end
            if_c.data_in = cur_in;
        end
        vectors++;
        if (evq.size() != 0) begin
            miscompares++;
            $display("FAIL random_drain: %0d events outstanding, want 0", evq.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_filter();
        test_independence();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
